stream_byte_packer: RTL

Upstream packing stage for the `skid_buffer`: accepts an 8-bit AXI-Stream byte stream with `tlast` and packs `n` consecutive bytes into one `nb`-bit output word with per-byte `tkeep`. When `in_tlast` arrives, the partially filled word is flushed. The output is a registered AXI-Stream master that drives the skid buffer's `in_*` side directly. Sustained throughput is one byte per cycle with no bubbles at word boundaries while `out_tready` stays high.

---
 rtl/stream_byte_packer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/stream_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into n-lane words with tkeep, flushing on tlast.
// Define STREAM_BYTE_PACKER_MSB_FIRST_EN to place the first byte in the top lane.
module stream_byte_packer #(
    parameter int unsigned n = 5,
    localparam int unsigned nb = n * 8
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [7:0]    in_tdata,
    input  logic          in_tvalid,
    input  logic          in_tlast,
    output logic          in_tready,
    output logic [nb-1:0] out_tdata,
    output logic [n-1:0]  out_tkeep,
    output logic          out_tlast,
    output logic          out_tvalid,
    input  logic          out_tready
);

    localparam int unsigned CntW = $clog2(n);
    localparam logic [CntW-1:0] LastLane = CntW'(n - 1);

    logic [n-2:0][7:0] acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [nb-1:0]     out_tdata_q, out_tdata_d;
    logic [n-1:0]      out_tkeep_q, out_tkeep_d;
    logic              out_tlast_q, out_tlast_d;
    logic              out_tvalid_q, out_tvalid_d;

    logic              completing;
    logic              wr;
    logic              rd;
    logic [n-1:0][7:0] lin_byte;
    logic [n-1:0]      lin_keep;
    logic [n-1:0][7:0] word;
    logic [n-1:0]      word_keep;

    assign completing = (cnt_q == LastLane) || in_tlast;
    // Only a completing byte needs the output slot, so partial bytes flow in during a stall.
    assign in_tready  = !areset && !(out_tvalid_q && !out_tready && completing);
    assign wr         = in_tvalid && in_tready;
    assign rd         = out_tvalid_q && out_tready;

    // Word in arrival order: byte j sits in lin_byte[j].
    always_comb begin
        lin_byte = '0;
        lin_keep = '0;
        for (int j = 0; j < int'(n) - 1; j++) begin
            if (CntW'(j) < cnt_q) begin
                lin_byte[j] = acc_q[j];
            end
        end
        for (int j = 0; j < int'(n); j++) begin
            if (CntW'(j) == cnt_q) begin
                lin_byte[j] = in_tdata;
            end
            lin_keep[j] = (CntW'(j) <= cnt_q);
        end
    end

    always_comb begin
        word      = '0;
        word_keep = '0;
        for (int k = 0; k < int'(n); k++) begin
`ifdef STREAM_BYTE_PACKER_MSB_FIRST_EN
            word[k]      = lin_byte[int'(n) - 1 - k];
            word_keep[k] = lin_keep[int'(n) - 1 - k];
`else
            word[k]      = lin_byte[k];
            word_keep[k] = lin_keep[k];
`endif
        end
    end

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_tdata_d  = out_tdata_q;
        out_tkeep_d  = out_tkeep_q;
        out_tlast_d  = out_tlast_q;
        out_tvalid_d = out_tvalid_q;
        if (rd) begin
            out_tvalid_d = 1'b0;
        end
        if (wr) begin
            if (completing) begin
                out_tdata_d  = word;
                out_tkeep_d  = word_keep;
                out_tlast_d  = in_tlast;
                out_tvalid_d = 1'b1;
                cnt_d        = '0;
            end else begin
                for (int j = 0; j < int'(n) - 1; j++) begin
                    if (cnt_q == CntW'(j)) begin
                        acc_d[j] = in_tdata;
                    end
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_tdata_q  <= out_tdata_d;
            out_tkeep_q  <= out_tkeep_d;
            out_tlast_q  <= out_tlast_d;
            out_tvalid_q <= out_tvalid_d;
        end
    end

    assign out_tdata  = out_tdata_q;
    assign out_tkeep  = out_tkeep_q;
    assign out_tlast  = out_tlast_q;
    assign out_tvalid = out_tvalid_q;

endmodule
